// File: rtl/count_ctrl.sv
// Run/direction sequencer for the up/down display counter: turns run, direction and clear
// buttons into counter enable/direction/clear. Optional auto-reverse at limits: COUNT_CTRL_BOUNCE_EN.
module count_ctrl #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned CNT_MAX = 15
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Tick,
  input  logic             BtnRun,
  input  logic             BtnDir,
  input  logic             BtnClr,
  input  logic [WIDTH-1:0] CntVal,
  output logic             CntEn,
  output logic             CntUp,
  output logic             CntClr,
  output logic [1:0]       State,
  output logic             AtLimit
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN_UP = 2'b01,
    ST_RUN_DN = 2'b10,
    ST_HOLD   = 2'b11
  } state_t;

  state_t     r_state;
  logic       r_dir;
  logic       r_clr;
  logic [1:0] r_run_sync;
  logic [1:0] r_dir_sync;
  logic [1:0] r_clr_sync;
  logic       r_run_prev;
  logic       r_dir_prev;
  logic       r_clr_prev;

  logic       w_run_p;
  logic       w_dir_p;
  logic       w_clr_p;
  logic       w_running;
  logic       w_at_limit;

  // One-cycle press pulses from the synchronised button levels
  assign w_run_p = r_run_sync[1] & ~r_run_prev;
  assign w_dir_p = r_dir_sync[1] & ~r_dir_prev;
  assign w_clr_p = r_clr_sync[1] & ~r_clr_prev;

  assign w_running  = (r_state == ST_RUN_UP) || (r_state == ST_RUN_DN);
  assign w_at_limit = ((r_state == ST_RUN_UP) && (CntVal == WIDTH'(CNT_MAX))) ||
                      ((r_state == ST_RUN_DN) && (CntVal == '0));

  assign AtLimit = w_at_limit;
  assign CntEn   = Tick & w_running & ~w_at_limit & ~w_clr_p;
  assign CntUp   = (r_state == ST_RUN_UP) ? 1'b1 :
                   (r_state == ST_RUN_DN) ? 1'b0 : r_dir;
  assign CntClr  = r_clr;
  assign State   = r_state;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state    <= ST_IDLE;
      r_dir      <= 1'b1;
      r_clr      <= 1'b0;
      r_run_sync <= 2'b00;
      r_dir_sync <= 2'b00;
      r_clr_sync <= 2'b00;
      r_run_prev <= 1'b0;
      r_dir_prev <= 1'b0;
      r_clr_prev <= 1'b0;
    end else begin
      r_run_sync <= {r_run_sync[0], BtnRun};
      r_dir_sync <= {r_dir_sync[0], BtnDir};
      r_clr_sync <= {r_clr_sync[0], BtnClr};
      r_run_prev <= r_run_sync[1];
      r_dir_prev <= r_dir_sync[1];
      r_clr_prev <= r_clr_sync[1];
      r_clr      <= 1'b0;

      // Priority: clear, run/pause, direction, then limit handling on a tick
      if (w_clr_p) begin
        r_state <= ST_IDLE;
        r_clr   <= 1'b1;
      end else if (w_run_p) begin
        case (r_state)
          ST_IDLE, ST_HOLD: r_state <= r_dir ? ST_RUN_UP : ST_RUN_DN;
          default:          r_state <= ST_HOLD;
        endcase
      end else if (w_dir_p) begin
        r_dir <= ~r_dir;
        case (r_state)
          ST_RUN_UP: r_state <= ST_RUN_DN;
          ST_RUN_DN: r_state <= ST_RUN_UP;
          default:   r_state <= r_state;
        endcase
      end else if (Tick && w_at_limit) begin
`ifdef COUNT_CTRL_BOUNCE_EN
        r_dir   <= ~r_dir;
        r_state <= (r_state == ST_RUN_UP) ? ST_RUN_DN : ST_RUN_UP;
`else
        r_state <= ST_HOLD;
`endif
      end
    end
  end

endmodule
